// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, the default NOP word and the issue-FSM state type.
package riscv_pkg;

  localparam logic [6:0] R_TYPE_OP    = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP    = 7'b0010011;
  localparam logic [6:0] B_TYPE_OP    = 7'b1100011;
  localparam logic [6:0] S_TYPE_OP    = 7'b0100011;
  localparam logic [6:0] L_TYPE_OP    = 7'b0000011;
  localparam logic [6:0] J_TYPE_OP    = 7'b1101111;
  localparam logic [6:0] JALR_TYPE_OP = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; flush empties it and overrides push/pop.
module instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [XLEN-1:0]          push_data_i,
  input  logic                     pop_i,
  output logic [XLEN-1:0]          pop_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     level_q;
  logic            do_push, do_pop;

  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  // full is registered, so a same-cycle pop never frees a slot for a push
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers instruction words and issues each to the core for HOLD_CYCLES,
// followed by GAP_CYCLES of NOP, in auto or single-step mode.
module instr_issue_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 8,
  parameter int unsigned     HOLD_CYCLES = 4,
  parameter int unsigned     GAP_CYCLES  = 0,
  parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(DEFAULT_NOP_INSTR),
  parameter int unsigned     CNT_W       = 16
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic                   push_valid,
  input  logic [XLEN-1:0]        push_instr,
  output logic                   push_ready,
  input  logic                   flush,
  input  logic                   auto_mode,
  input  logic                   pause,
  input  logic                   step,
  output logic [XLEN-1:0]        cpu_instruction,
  output logic                   cpu_instruction_RDY_BSY,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   empty,
  output logic                   overflow,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic                   busy
);

  localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [GC_W-1:0] GAP_LOAD  = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  issue_state_e     state_q, state_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [GC_W-1:0]  gap_q, gap_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             overflow_q;
  logic             full, fifo_empty, go, pop;
  logic [XLEN-1:0]  head;

  instr_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk_i       (cpu_clk),
    .rst_i       (cpu_rst),
    .flush_i     (flush),
    .push_i      (push_valid),
    .push_data_i (push_instr),
    .pop_i       (pop),
    .pop_data_o  (head),
    .level_o     (fifo_level),
    .full_o      (full),
    .empty_o     (fifo_empty)
  );

  assign go = !fifo_empty && !flush && (auto_mode ? !pause : step);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    instr_d  = instr_q;
    issued_d = issued_q;
    pop      = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: pop = go;
        ST_HOLD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HC_W'(1);
          end else if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (go) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // last gap cycle issues directly so the gap is exactly GAP_CYCLES long
        ST_GAP: begin
          if (gap_q != '0)  gap_d   = gap_q - GC_W'(1);
          else if (go)      pop     = 1'b1;
          else              state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (pop) begin
      state_d  = ST_HOLD;
      instr_d  = head;
      hold_d   = HOLD_LOAD;
      issued_d = issued_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      gap_q    <= '0;
      instr_q  <= NOP_INSTR;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      instr_q  <= instr_d;
      issued_q <= issued_d;
    end
  end

  // a push dropped by flush is not an overflow
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)                           overflow_q <= 1'b0;
    else if (push_valid && full && !flush) overflow_q <= 1'b1;
  end

  assign push_ready              = !full;
  assign empty                   = fifo_empty;
  assign overflow                = overflow_q;
  assign issued_cnt              = issued_q;
  assign busy                    = (state_q != ST_IDLE);
  assign cpu_instruction_RDY_BSY = (state_q == ST_HOLD);
  assign cpu_instruction         = (state_q == ST_HOLD) ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: default instance plus a HOLD=1/GAP=2 instance.
module tb_instr_issue_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned HOLD  = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst = 1'b1;
  logic          push_valid, flush, auto_mode, pause, step;
  logic [31:0]   push_instr;
  logic          push_ready, rdy, empty, overflow, busy;
  logic [31:0]   cpu_instr;
  logic [LW-1:0] level;
  logic [15:0]   issued;

  logic          g_push_valid;
  logic [31:0]   g_push_instr;
  logic          g_push_ready, g_rdy, g_empty, g_overflow, g_busy;
  logic [31:0]   g_instr;
  logic [LW-1:0] g_level;
  logic [15:0]   g_issued;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gexp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  instr_issue_queue dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst                 (cpu_rst),
    .push_valid              (push_valid),
    .push_instr              (push_instr),
    .push_ready              (push_ready),
    .flush                   (flush),
    .auto_mode               (auto_mode),
    .pause                   (pause),
    .step                    (step),
    .cpu_instruction         (cpu_instr),
    .cpu_instruction_RDY_BSY (rdy),
    .fifo_level              (level),
    .empty                   (empty),
    .overflow                (overflow),
    .issued_cnt              (issued),
    .busy                    (busy)
  );

  instr_issue_queue #(
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (2)
  ) dut_gap (
    .cpu_clk                 (cpu_clk),
    .cpu_rst                 (cpu_rst),
    .push_valid              (g_push_valid),
    .push_instr              (g_push_instr),
    .push_ready              (g_push_ready),
    .flush                   (1'b0),
    .auto_mode               (1'b1),
    .pause                   (1'b0),
    .step                    (1'b0),
    .cpu_instruction         (g_instr),
    .cpu_instruction_RDY_BSY (g_rdy),
    .fifo_level              (g_level),
    .empty                   (g_empty),
    .overflow                (g_overflow),
    .issued_cnt              (g_issued),
    .busy                    (g_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    push_valid = 1'b1;
    push_instr = w;
    if (accepted) exp_q.push_back(w);
    @(negedge cpu_clk);
    push_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge cpu_clk);
    step = 1'b0;
  endtask

  // Entered on a negedge; waits for an issue, then checks HOLD cycles of the popped word.
  task automatic expect_issue(input string tag, input int unsigned max_wait);
    logic [31:0] w;
    int unsigned waited = 0;
    while (rdy !== 1'b1 && waited < max_wait) begin
      @(negedge cpu_clk);
      waited++;
    end
    if (rdy !== 1'b1) begin
      check_eq({tag, "_timeout"}, rdy, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_size"}, exp_q.size(), 1);
      return;
    end
    w = exp_q.pop_front();
    for (int i = 0; i < HOLD; i++) begin
      check_eq({tag, "_word"}, cpu_instr, w);
      check_eq({tag, "_rdy"}, rdy, 1);
      @(negedge cpu_clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned w;
    push_valid   = 1'b0;
    push_instr   = '0;
    flush        = 1'b0;
    auto_mode    = 1'b1;
    pause        = 1'b0;
    step         = 1'b0;
    g_push_valid = 1'b0;
    g_push_instr = '0;

    // reset state
    repeat (2) @(negedge cpu_clk);
    check_eq("rst_instr", cpu_instr, NOP);
    check_eq("rst_rdy", rdy, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_push_ready", push_ready, 1);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_issued", issued, 0);
    check_eq("rst_busy", busy, 0);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);

    // 1: auto mode, three back-to-back 4-cycle holds
    fork
      begin
        push_word(32'h0050_0093, 1'b1);
        push_word(32'h0050_8113, 1'b1);
        push_word(32'h0020_81B3, 1'b1);
      end
      begin
        expect_issue("t1_a", 5);
        expect_issue("t1_b", 0);
        expect_issue("t1_c", 0);
      end
    join
    check_eq("t1_end_rdy", rdy, 0);
    check_eq("t1_end_instr", cpu_instr, NOP);
    check_eq("t1_issued", issued, 3);
    check_eq("t1_empty", empty, 1);

    // 2: HOLD=1, GAP=2 -> A, NOP, NOP, B
    g_push_valid = 1'b1;
    g_push_instr = 32'h0010_0093;
    gexp_q.push_back(g_push_instr);
    @(negedge cpu_clk);
    g_push_instr = 32'h0020_0113;
    gexp_q.push_back(g_push_instr);
    @(negedge cpu_clk);
    g_push_valid = 1'b0;
    w = 0;
    while (g_rdy !== 1'b1 && w < 4) begin
      @(negedge cpu_clk);
      w++;
    end
    check_eq("t2_a_rdy", g_rdy, 1);
    check_eq("t2_a_word", g_instr, gexp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk);
      check_eq("t2_gap_rdy", g_rdy, 0);
      check_eq("t2_gap_instr", g_instr, NOP);
    end
    @(negedge cpu_clk);
    check_eq("t2_b_rdy", g_rdy, 1);
    check_eq("t2_b_word", g_instr, gexp_q.pop_front());
    @(negedge cpu_clk);
    check_eq("t2_end_rdy", g_rdy, 0);

    // 3: step mode; no step -> no issue; a step during a hold is ignored
    auto_mode = 1'b0;
    push_word(32'h0030_0193, 1'b1);
    push_word(32'h0040_0213, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_idle_rdy", rdy, 0);
      @(negedge cpu_clk);
    end
    check_eq("t3_level2", level, 2);
    pulse_step();
    fork
      expect_issue("t3_w0", 2);
      begin
        @(negedge cpu_clk);
        check_eq("t3_level1", level, 1);
        step = 1'b1;
        @(negedge cpu_clk);
        step = 1'b0;
      end
    join
    check_eq("t3_after_rdy", rdy, 0);
    check_eq("t3_step_ignored_level", level, 1);
    check_eq("t3_issued", issued, 4);
    pulse_step();
    expect_issue("t3_w1", 2);
    check_eq("t3_issued2", issued, 5);

    // 4: fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + 32'(i * 4), 1'b1);
    check_eq("t4_full_ready", push_ready, 0);
    check_eq("t4_full_level", level, DEPTH);
    push_word(32'hDEAD_BEEF, 1'b0);
    check_eq("t4_overflow", overflow, 1);
    check_eq("t4_level_kept", level, DEPTH);
    check_eq("t4_ready_kept", push_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      pulse_step();
      expect_issue("t4_drain", 2);
    end
    check_eq("t4_empty", empty, 1);
    check_eq("t4_issued", issued, 13);
    check_eq("t4_overflow_sticky", overflow, 1);

    // 5: flush during second hold cycle
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_q.delete();
    check_eq("t5_rst_overflow", overflow, 0);
    auto_mode = 1'b1;
    pause     = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'h2000_0000 + 32'(i), 1'b1);
    check_eq("t5_paused_level", level, 6);
    check_eq("t5_paused_rdy", rdy, 0);
    pause = 1'b0;
    @(negedge cpu_clk);
    check_eq("t5_hold1_word", cpu_instr, exp_q[0]);
    @(negedge cpu_clk);
    check_eq("t5_hold2_level", level, 5);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_instr = 32'h1234_5678;
    @(negedge cpu_clk);
    flush      = 1'b0;
    push_valid = 1'b0;
    check_eq("t5_flush_rdy", rdy, 0);
    check_eq("t5_flush_instr", cpu_instr, NOP);
    check_eq("t5_flush_level", level, 0);
    check_eq("t5_flush_issued", issued, 1);
    check_eq("t5_flush_overflow", overflow, 0);
    check_eq("t5_flush_busy", busy, 0);
    @(negedge cpu_clk);
    check_eq("t5_post_rdy", rdy, 0);
    exp_q.delete();

    // 6: asynchronous reset mid-hold
    push_word(32'h0070_0393, 1'b1);
    push_word(32'h0080_0413, 1'b1);
    w = 0;
    while (rdy !== 1'b1 && w < 4) begin
      @(negedge cpu_clk);
      w++;
    end
    check_eq("t6_pre_rdy", rdy, 1);
    #2 cpu_rst = 1'b1;
    #1;
    check_eq("t6_async_rdy", rdy, 0);
    check_eq("t6_async_instr", cpu_instr, NOP);
    check_eq("t6_async_level", level, 0);
    check_eq("t6_async_issued", issued, 0);
    check_eq("t6_async_busy", busy, 0);
    check_eq("t6_async_ready", push_ready, 1);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_q.delete();
    push_word(32'h0090_0493, 1'b1);
    expect_issue("t6_new", 3);
    check_eq("t6_new_issued", issued, 1);
    check_eq("t6_new_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
